button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Classifies debounced button activity into discrete user events: short press, long press, and double click. It sits directly downstream of the synchronizer/debounce stage and consumes its debounced level and `edges_t` rising/falling pulses. It emits one single-cycle event pulse per gesture to the control path.

## Interface
- `LONG_PRESS_CYCLES`, default 50_000_000: hold duration, in clocks, that qualifies a press as LONG. Must be ≥2.
- `DOUBLE_GAP_CYCLES`, default 12_500_000: maximum release-to-press gap, in clocks, for a DOUBLE. Must be ≥2. Unused when double-click is compiled out.
- `i_clk`  input  1  system clock. Single clock domain.
- `i_reset_n`  input  1  reset. Synchronous, active-low.
- `i_signal_syncd`  input  1  debounced button level. Used only for the idle sanity check.
- `i_edges`  input  `edges_t`  rising/falling single-cycle pulses from the upstream stage.
- `o_event_valid`  output  1  single-cycle pulse; high when an event is reported.
- `o_event`  output  `button_event_t`  event type. Equals `EV_NONE` whenever `o_event_valid` is 0.
- `o_event_count`  output  8  count of events emitted. Wraps from 255 to 0.
- `o_busy`  output  1  high when the FSM is not in IDLE.

## Operation
- **Edge validity:** an edge is valid only if exactly one of `rising`/`falling` is set. Both set in the same cycle means both are ignored.
- **FSM states:** IDLE, PRESSED, GAP, RELEASE_WAIT. One counter `cnt` is cleared on every state entry and increments by 1 each cycle while in PRESSED or GAP.
- **IDLE:**
  - rising → PRESSED.
  - falling is ignored.
  - If `i_signal_syncd`=1 with no rising edge (button held across reset), stay in IDLE.
- **PRESSED:**
  - falling → GAP when double-click is enabled; otherwise emit SHORT and go to IDLE.
  - Else, if `cnt == LONG_PRESS_CYCLES-1`, emit LONG and go to RELEASE_WAIT.
  - If falling and the threshold coincide, falling wins.
- **GAP:**
  - rising → emit DOUBLE and go to RELEASE_WAIT.
  - Else, if `cnt == DOUBLE_GAP_CYCLES-1`, emit SHORT and go to IDLE.
  - If rising and the threshold coincide, rising wins (DOUBLE).
  - falling is ignored.
- **RELEASE_WAIT:**
  - falling → IDLE, with no event.
  - rising is ignored.
- **Counter width:** `$clog2(max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES)+1)`. Saturates and never wraps; with legal parameters it never reaches saturation.
- **Event output:** `o_event_valid`/`o_event` are registered from the transition decision. At most one event per cycle.
- **Event count:** `o_event_count` increments in the same cycle that `o_event_valid` is high. Modulo 256.
- **Busy:** `o_busy` is registered, equal to (next state ≠ IDLE).

## Timing
- **Reset values:** FSM = IDLE, `cnt`=0, `o_event_valid`=0, `o_event`=`EV_NONE`, `o_event_count`=0, `o_busy`=0.
- **Reset mid-gesture:** reset asserted mid-gesture returns to IDLE on the next clock edge, with no event emitted and no partial event.
- **Edge latency:** an edge sampled at cycle N → the FSM moves at N+1. Any event triggered by that edge is visible at N+1.
- **LONG latency:** rising edge at cycle N, held → LONG valid at cycle N+LONG_PRESS_CYCLES+1.
- **SHORT latency (double-click enabled):** falling edge at cycle M, no further rising → SHORT valid at cycle M+DOUBLE_GAP_CYCLES+1.
- **SHORT latency (double-click disabled):** SHORT valid at cycle M+1.
- **Back-to-back:** a new rising edge is accepted the cycle after return to IDLE.

## Configuration
- Macro: `BUTTON_DOUBLE_CLICK_EN`.
- **Defined:** the GAP state exists. SHORT is deferred by the gap window, and DOUBLE can be emitted.
- **Undefined:** the GAP state and its logic are compiled out. Falling in PRESSED emits SHORT immediately; `EV_DOUBLE` is never produced. `DOUBLE_GAP_CYCLES` is ignored, and counter width uses `LONG_PRESS_CYCLES` alone.

## Structure
- **Shared package `pipeline_types`:**
  - `button_event_t`, a 2-bit enum: `EV_NONE`=0, `EV_SHORT`=1, `EV_LONG`=2, `EV_DOUBLE`=3.
  - `RESET_VALUES_BUTTON_EVENT` constant.
  - Reuse the existing `edges_t`.
- **Local to the module:** FSM state enum.
- **Sub-module:** `press_timer`, a clear/enable/threshold counter. It is instantiated once and shared by PRESSED and GAP.

## Test plan
Bench parameters: LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=4.
- Rising at c10, falling at c13, nothing after → SHORT valid at c18. Count 0→1. `o_busy` low from c18.
- Rising at c10, held → LONG valid at c19. The later falling at c30 produces no event. Busy drops at c31.
- Rising c10, falling c12, rising c14 → DOUBLE valid at c15, no SHORT. Falling c20 → IDLE, no event.
- Coincidence cases:
  - Falling exactly at the LONG threshold cycle → SHORT path, no LONG.
  - Rising exactly at the gap threshold → DOUBLE.
  - Rising and falling both set in one cycle → ignored.
- Reset pulse in PRESSED at c15 → no event, all outputs at reset values. 256 SHORT gestures → count wraps to 0.
- Build with `BUTTON_DOUBLE_CLICK_EN` undefined: rising c10, falling c12 → SHORT valid at c13. Rising c14 → PRESSED, never DOUBLE.

Source files
------------

// File: rtl/pipeline_types_pkg.sv
// Types shared along the button pipeline: debounced edge pulses and decoded user events.
package pipeline_types;

    typedef struct packed {
        logic rising;
        logic falling;
    } edges_t;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_SHORT  = 2'd1,
        EV_LONG   = 2'd2,
        EV_DOUBLE = 2'd3
    } button_event_t;

    localparam button_event_t RESET_VALUES_BUTTON_EVENT = EV_NONE;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_press_timer.sv
// press_timer: clearable, saturating up-counter with an equality-threshold flag.
module press_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [Width-1:0] threshold,
    output logic             hit
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == threshold);

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced button edges into SHORT / LONG / DOUBLE event pulses.
// Define BUTTON_DOUBLE_CLICK_EN to build the GAP state and double-click detection.
module button_event_decoder
    import pipeline_types::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 12_500_000
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_signal_syncd,
    input  edges_t        i_edges,
    output logic          o_event_valid,
    output button_event_t o_event,
    output logic [7:0]    o_event_count,
    output logic          o_busy
);

`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam int unsigned MaxCycles = max_u(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES);
`else
    localparam int unsigned MaxCycles = LONG_PRESS_CYCLES;
`endif
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    if (LONG_PRESS_CYCLES < 2 || DOUBLE_GAP_CYCLES < 2) begin : gen_param_check
        $error("button_event_decoder: cycle parameters must be >= 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
`ifdef BUTTON_DOUBLE_CLICK_EN
        StGap,
`endif
        StReleaseWait
    } state_e;

    state_e        state_q, state_d;
    button_event_t ev_d;
    logic          rise, fall;
    logic          hit;
    logic          timer_en;
    logic [CntW-1:0] threshold;

    // Simultaneous rising and falling pulses are contradictory and dropped.
    assign rise = i_edges.rising & ~i_edges.falling;
    assign fall = i_edges.falling & ~i_edges.rising;

`ifdef BUTTON_DOUBLE_CLICK_EN
    assign timer_en  = (state_q == StPressed) || (state_q == StGap);
    assign threshold = (state_q == StGap) ? CntW'(DOUBLE_GAP_CYCLES - 1)
                                          : CntW'(LONG_PRESS_CYCLES - 1);
`else
    assign timer_en  = (state_q == StPressed);
    assign threshold = CntW'(LONG_PRESS_CYCLES - 1);
`endif

    press_timer #(
        .Width (CntW)
    ) u_press_timer (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .clear     (state_d != state_q),
        .enable    (timer_en),
        .threshold (threshold),
        .hit       (hit)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= StIdle;
            o_event_valid <= 1'b0;
            o_event       <= RESET_VALUES_BUTTON_EVENT;
            o_event_count <= 8'd0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            o_event_valid <= (ev_d != EV_NONE);
            o_event       <= ev_d;
            if (ev_d != EV_NONE) begin
                o_event_count <= o_event_count + 8'd1;
            end
            o_busy        <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPressed;
                end else if (i_signal_syncd) begin
                    // Held across reset: wait for a fresh rising edge.
                    state_d = StIdle;
                end
            end
            StPressed: begin
                if (fall) begin
`ifdef BUTTON_DOUBLE_CLICK_EN
                    state_d = StGap;
`else
                    state_d = StIdle;
`endif
                end else if (hit) begin
                    state_d = StReleaseWait;
                end
            end
`ifdef BUTTON_DOUBLE_CLICK_EN
            StGap: begin
                if (rise) begin
                    state_d = StReleaseWait;
                end else if (hit) begin
                    state_d = StIdle;
                end
            end
`endif
            StReleaseWait: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ev_d = EV_NONE;
        unique case (state_q)
            StPressed: begin
                if (!fall && hit) begin
                    ev_d = EV_LONG;
                end
`ifndef BUTTON_DOUBLE_CLICK_EN
                if (fall) begin
                    ev_d = EV_SHORT;
                end
`endif
            end
`ifdef BUTTON_DOUBLE_CLICK_EN
            StGap: begin
                if (rise) begin
                    ev_d = EV_DOUBLE;
                end else if (hit) begin
                    ev_d = EV_SHORT;
                end
            end
`endif
            default: ev_d = EV_NONE;
        endcase
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder; follows BUTTON_DOUBLE_CLICK_EN like the DUT.
module tb_button_event_decoder;
    import pipeline_types::*;

    localparam int unsigned LongCycles = 8;
    localparam int unsigned GapCycles  = 4;
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam int ShortLat = GapCycles + 1;
`else
    localparam int ShortLat = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          signal_syncd = 1'b0;
    edges_t        edges = '0;
    logic          ev_valid;
    button_event_t ev_type;
    logic [7:0]    ev_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_PRESS_CYCLES (LongCycles),
        .DOUBLE_GAP_CYCLES (GapCycles)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_signal_syncd (signal_syncd),
        .i_edges        (edges),
        .o_event_valid  (ev_valid),
        .o_event        (ev_type),
        .o_event_count  (ev_count),
        .o_busy         (busy)
    );

    // Present edges for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit r, input bit f);
        edges.rising  = r;
        edges.falling = f;
        if (r && !f) signal_syncd = 1'b1;
        else if (f && !r) signal_syncd = 1'b0;
        @(posedge clk);
        #1;
        edges = '0;
    endtask

    task automatic do_reset;
        reset_n      = 1'b0;
        edges        = '0;
        signal_syncd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (ev_valid !== 1'b0 || ev_type !== EV_NONE || ev_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%b ev=%0d cnt=%0d busy=%b, want 0/0/0/0",
                     ev_valid, ev_type, ev_count, busy);
        end
    endtask

    task automatic test_short;
        button_event_t exp_ev;
        logic exp_busy;
        do_reset;
        for (int c = 0; c < 30; c++) begin
            step(c == 10, c == 13);
            exp_ev   = (c + 1 == 13 + ShortLat) ? EV_SHORT : EV_NONE;
            exp_busy = (c + 1 >= 11) && (c + 1 < 13 + ShortLat);
            checks++;
            if (ev_valid !== (exp_ev != EV_NONE) || ev_type !== exp_ev) begin
                errors++;
                $display("FAIL short_event c%0d: got v=%b ev=%0d, want ev=%0d",
                         c + 1, ev_valid, ev_type, exp_ev);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL short_busy c%0d: got %b, want %b", c + 1, busy, exp_busy);
            end
        end
        checks++;
        if (ev_count !== 8'd1) begin
            errors++;
            $display("FAIL short_count: got %0d, want 1", ev_count);
        end
    endtask

    task automatic test_long;
        button_event_t exp_ev;
        logic exp_busy;
        do_reset;
        for (int c = 0; c < 35; c++) begin
            step(c == 10, c == 30);
            exp_ev   = (c + 1 == 10 + LongCycles + 1) ? EV_LONG : EV_NONE;
            exp_busy = (c + 1 >= 11) && (c + 1 <= 30);
            checks++;
            if (ev_valid !== (exp_ev != EV_NONE) || ev_type !== exp_ev) begin
                errors++;
                $display("FAIL long_event c%0d: got v=%b ev=%0d, want ev=%0d",
                         c + 1, ev_valid, ev_type, exp_ev);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL long_busy c%0d: got %b, want %b", c + 1, busy, exp_busy);
            end
        end
        checks++;
        if (ev_count !== 8'd1) begin
            errors++;
            $display("FAIL long_count: got %0d, want 1", ev_count);
        end
    endtask

    task automatic test_double;
        button_event_t exp_ev;
        logic exp_busy;
        int exp_cnt;
        do_reset;
        for (int c = 0; c < 25; c++) begin
            step(c == 10 || c == 14, c == 12 || c == 20);
`ifdef BUTTON_DOUBLE_CLICK_EN
            exp_ev   = (c + 1 == 15) ? EV_DOUBLE : EV_NONE;
            exp_busy = (c + 1 >= 11) && (c + 1 <= 20);
            exp_cnt  = 1;
`else
            exp_ev   = (c + 1 == 13 || c + 1 == 21) ? EV_SHORT : EV_NONE;
            exp_busy = ((c + 1 >= 11) && (c + 1 <= 12)) || ((c + 1 >= 15) && (c + 1 <= 20));
            exp_cnt  = 2;
`endif
            checks++;
            if (ev_valid !== (exp_ev != EV_NONE) || ev_type !== exp_ev) begin
                errors++;
                $display("FAIL double_event c%0d: got v=%b ev=%0d, want ev=%0d",
                         c + 1, ev_valid, ev_type, exp_ev);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL double_busy c%0d: got %b, want %b", c + 1, busy, exp_busy);
            end
        end
        checks++;
        if (ev_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL double_count: got %0d, want %0d", ev_count, exp_cnt);
        end
    endtask

    // Falling lands on the same cycle the LONG threshold is reached.
    task automatic test_coincide_long;
        button_event_t exp_ev;
        logic exp_busy;
        do_reset;
        for (int c = 0; c < 30; c++) begin
            step(c == 10, c == 10 + LongCycles);
            exp_ev   = (c + 1 == 10 + LongCycles + ShortLat) ? EV_SHORT : EV_NONE;
            exp_busy = (c + 1 >= 11) && (c + 1 < 10 + LongCycles + ShortLat);
            checks++;
            if (ev_valid !== (exp_ev != EV_NONE) || ev_type !== exp_ev) begin
                errors++;
                $display("FAIL coincide_long c%0d: got v=%b ev=%0d, want ev=%0d",
                         c + 1, ev_valid, ev_type, exp_ev);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL coincide_long_busy c%0d: got %b, want %b", c + 1, busy, exp_busy);
            end
        end
    endtask

`ifdef BUTTON_DOUBLE_CLICK_EN
    // Second rising lands on the last cycle of the gap window.
    task automatic test_coincide_gap;
        button_event_t exp_ev;
        logic exp_busy;
        do_reset;
        for (int c = 0; c < 28; c++) begin
            step(c == 10 || c == 13 + GapCycles, c == 13 || c == 22);
            exp_ev   = (c + 1 == 14 + GapCycles) ? EV_DOUBLE : EV_NONE;
            exp_busy = (c + 1 >= 11) && (c + 1 <= 22);
            checks++;
            if (ev_valid !== (exp_ev != EV_NONE) || ev_type !== exp_ev) begin
                errors++;
                $display("FAIL coincide_gap c%0d: got v=%b ev=%0d, want ev=%0d",
                         c + 1, ev_valid, ev_type, exp_ev);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL coincide_gap_busy c%0d: got %b, want %b", c + 1, busy, exp_busy);
            end
        end
    endtask
`endif

    // Both pulses at once: ignored in IDLE, in PRESSED and in RELEASE_WAIT.
    task automatic test_both_edges;
        button_event_t exp_ev;
        logic exp_busy;
        do_reset;
        for (int c = 0; c < 30; c++) begin
            step(c == 10 || c == 12 || c == 14 || c == 23, c == 10 || c == 14 || c == 23 || c == 25);
            exp_ev   = (c + 1 == 12 + LongCycles + 1) ? EV_LONG : EV_NONE;
            exp_busy = (c + 1 >= 13) && (c + 1 <= 25);
            checks++;
            if (ev_valid !== (exp_ev != EV_NONE) || ev_type !== exp_ev) begin
                errors++;
                $display("FAIL both_edges c%0d: got v=%b ev=%0d, want ev=%0d",
                         c + 1, ev_valid, ev_type, exp_ev);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL both_edges_busy c%0d: got %b, want %b", c + 1, busy, exp_busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (ShortLat + 2) step(1'b0, 1'b0);
        checks++;
        if (ev_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_pre_count: got %0d, want 1", ev_count);
        end
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        reset_n = 1'b0;
        step(1'b0, 1'b0);
        reset_n = 1'b1;
        checks++;
        if (ev_valid !== 1'b0 || ev_type !== EV_NONE || ev_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_values: got v=%b ev=%0d cnt=%0d busy=%b, want 0/0/0/0",
                     ev_valid, ev_type, ev_count, busy);
        end
        // Button still held after reset; the release must not produce anything.
        for (int c = 0; c < 15; c++) begin
            step(1'b0, c == 2);
            checks++;
            if (ev_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after c%0d: got v=%b busy=%b, want 0/0", c, ev_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (ShortLat - 1) step(1'b0, 1'b0);
        checks++;
        if (ev_type !== EV_SHORT || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got ev=%0d busy=%b, want ev=%0d busy=0",
                     ev_type, busy, EV_SHORT);
        end
        step(1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b v=%b, want busy=1 v=0", busy, ev_valid);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        for (int g = 1; g <= 256; g++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
            repeat (ShortLat - 1) step(1'b0, 1'b0);
            checks++;
            if (ev_valid !== 1'b1 || ev_type !== EV_SHORT || ev_count !== 8'(g % 256)) begin
                errors++;
                $display("FAIL wrap_gesture_%0d: got v=%b ev=%0d cnt=%0d, want v=1 ev=%0d cnt=%0d",
                         g, ev_valid, ev_type, ev_count, EV_SHORT, g % 256);
            end
        end
    endtask

    initial begin
        test_reset;
        test_short;
        test_long;
        test_double;
        test_coincide_long;
`ifdef BUTTON_DOUBLE_CLICK_EN
        test_coincide_gap;
`endif
        test_both_edges;
        test_reset_mid;
        test_back_to_back;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
